// File: rtl/imm_pkg.sv
// Immediate-format encodings shared by the immediate generator, decoder and program loader.
package imm_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_U = 3'b010,
        IMM_B = 3'b101,
        IMM_J = 3'b110
    } imm_src_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } load_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/imm_pack.sv
// Packs a signed immediate into an instruction template and reports whether it fits the format.
module imm_pack
    import imm_pkg::*;
(
    input  logic [XLEN-1:0] tmpl,
    input  logic [2:0]      src,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] word,
    output logic            encodable
);

    // Sign-extension checks: the bits above the field must all replicate the field's sign bit.
    logic fits_12;
    logic fits_13;
    logic fits_21;

    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        word      = tmpl;
        encodable = 1'b0;
        case (src)
            IMM_I: begin
                word[31:20] = imm[11:0];
                encodable   = fits_12;
            end
            IMM_S: begin
                word[31:25] = imm[11:5];
                word[11:7]  = imm[4:0];
                encodable   = fits_12;
            end
            IMM_U: begin
                word[31:12] = imm[31:12];
                encodable   = (imm[11:0] == 12'd0);
            end
            IMM_B: begin
                word[31]    = imm[12];
                word[7]     = imm[11];
                word[30:25] = imm[10:5];
                word[11:8]  = imm[4:1];
                encodable   = fits_13 & ~imm[0];
            end
            IMM_J: begin
                word[31]    = imm[20];
                word[19:12] = imm[19:12];
                word[20]    = imm[11];
                word[30:21] = imm[10:1];
                encodable   = fits_21 & ~imm[0];
            end
            default: begin
                word      = tmpl;
                encodable = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder_loader.sv
// Program-load front end: encodes immediates into instruction words and streams them into IMEM
// at consecutive word addresses through a one-entry output register.
module imm_encoder_loader
    import imm_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_tmpl,
    input  logic [2:0]       in_src,
    input  logic [31:0]      in_imm,
    input  logic             in_last,
    output logic             mem_we,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    load_state_e       state;
    load_state_e       state_nxt;
    mem_req_t          req_q;
    logic [31:0]       base_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] addr_idx;
    logic [31:0]       pk_word;
    logic              pk_ok;
    logic              accept;
    logic              mem_fire;

    imm_pack u_pack (
        .tmpl      (in_tmpl),
        .src       (in_src),
        .imm       (in_imm),
        .word      (pk_word),
        .encodable (pk_ok)
    );

    assign in_ready  = (state == S_LOAD) & (~mem_we | mem_ready);
    assign accept    = in_valid & in_ready;
    assign mem_fire  = mem_we & mem_ready;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

    // A write completing this cycle has not bumped idx yet, so the new word takes the next slot.
    assign addr_idx  = mem_we ? idx + ADDR_W'(1) : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (accept && in_last) state_nxt = S_DRAIN;
            S_DRAIN: if (!mem_we) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output register, word index and error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            req_q     <= '0;
            base_q    <= '0;
            idx       <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                base_q    <= base_addr & ~32'h3;
                idx       <= '0;
                err       <= 1'b0;
                err_count <= '0;
            end
            if (mem_fire) begin
                mem_we <= 1'b0;
                idx    <= idx + ADDR_W'(1);
            end
            if (accept) begin
                if (pk_ok) begin
                    mem_we      <= 1'b1;
                    req_q.addr  <= base_q + 32'({addr_idx, 2'b00});
                    req_q.wdata <= pk_word;
                end else begin
                    err <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder_loader.sv
// Directed bench for imm_encoder_loader: table of single-word sessions plus multi-cycle sequences.
module tb_imm_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_tmpl = '0;
    logic [2:0]  in_src = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        string       name;
        logic [31:0] tmpl;
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] exp_word;
        logic        exp_ok;
    } vec_t;

    imm_encoder_loader #(.ADDR_W(2), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tmpl   (in_tmpl),
        .in_src    (in_src),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Record completed IMEM writes and done pulses mid-cycle.
    always @(negedge clk) begin
        if (mem_we && mem_ready) wq.push_back({mem_addr, mem_wdata});
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] t, input logic [2:0] s, input logic [31:0] i,
                        input logic l);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_tmpl = t;
        in_src = s;
        in_imm = i;
        in_last = l;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    vec_t vecs[15];
    int   d0;

    initial begin
        vecs[0]  = '{"i_neg1",   32'h00000093, 3'b000, 32'hFFFFFFFF, 32'hFFF00093, 1'b1};
        vecs[1]  = '{"s_neg4",   32'h00002023, 3'b001, 32'hFFFFFFFC, 32'hFE002E23, 1'b1};
        vecs[2]  = '{"u_basic",  32'h000002B7, 3'b010, 32'h12345000, 32'h123452B7, 1'b1};
        vecs[3]  = '{"b_8",      32'h00000063, 3'b101, 32'h00000008, 32'h00000463, 1'b1};
        vecs[4]  = '{"b_neg2",   32'h00000063, 3'b101, 32'hFFFFFFFE, 32'hFE000FE3, 1'b1};
        vecs[5]  = '{"j_800",    32'h000000EF, 3'b110, 32'h00000800, 32'h001000EF, 1'b1};
        vecs[6]  = '{"j_neg2",   32'h000000EF, 3'b110, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b1};
        vecs[7]  = '{"i_max",    32'h00000093, 3'b000, 32'h000007FF, 32'h7FF00093, 1'b1};
        vecs[8]  = '{"i_min",    32'h00000093, 3'b000, 32'hFFFFF800, 32'h80000093, 1'b1};
        vecs[9]  = '{"i_tmplclr",32'hFFF00093, 3'b000, 32'h00000000, 32'h00000093, 1'b1};
        vecs[10] = '{"s_tmplclr",32'hFE000FA3, 3'b001, 32'h00000000, 32'h00000023, 1'b1};
        vecs[11] = '{"i_2048",   32'h00000093, 3'b000, 32'h00000800, 32'h0, 1'b0};
        vecs[12] = '{"b_odd",    32'h00000063, 3'b101, 32'h00000003, 32'h0, 1'b0};
        vecs[13] = '{"src_011",  32'h00000093, 3'b011, 32'h00000000, 32'h0, 1'b0};
        vecs[14] = '{"u_low",    32'h000002B7, 3'b010, 32'h12345001, 32'h0, 1'b0};

        // Reset state
        repeat (3) tick();
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick();

        // Table: one-word sessions at base 0x100
        foreach (vecs[k]) begin
            wq.delete();
            do_start(32'h103);
            send(vecs[k].tmpl, vecs[k].src, vecs[k].imm, 1'b1);
            wait_idle();
            check({vecs[k].name, "_nwr"}, 32'(wq.size()), 32'(vecs[k].exp_ok));
            check({vecs[k].name, "_err"}, 32'(err), 32'(!vecs[k].exp_ok));
            check({vecs[k].name, "_errcnt"}, 32'(err_count), 32'(!vecs[k].exp_ok));
            if (wq.size() == 1) begin
                check({vecs[k].name, "_addr"}, wq[0].addr, 32'h100);
                check({vecs[k].name, "_data"}, wq[0].data, vecs[k].exp_word);
            end
        end

        // Latency: accepted word drives mem_we in the next cycle
        wq.delete();
        do_start(32'h100);
        send(32'h00000093, 3'b000, 32'hFFFFFFFF, 1'b0);
        check("lat_mem_we", 32'(mem_we), 32'd1);
        check("lat_mem_addr", mem_addr, 32'h100);
        check("lat_mem_wdata", mem_wdata, 32'hFFF00093);
        send(32'h00000063, 3'b101, 32'h8, 1'b0);
        send(32'h000000EF, 3'b110, 32'h800, 1'b0);
        send(32'h000002B7, 3'b010, 32'h12345000, 1'b1);
        wait_idle();
        check("b2b_nwr", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) begin
            check("b2b_a1", wq[1].addr, 32'h104);
            check("b2b_d1", wq[1].data, 32'h00000463);
            check("b2b_a2", wq[2].addr, 32'h108);
            check("b2b_d2", wq[2].data, 32'h001000EF);
            check("b2b_a3", wq[3].addr, 32'h10C);
            check("b2b_d3", wq[3].data, 32'h123452B7);
        end

        // Error accumulation, index hold and saturation
        wq.delete();
        do_start(32'h600);
        send(32'h00000093, 3'b000, 32'h800, 1'b0);
        check("e1_err", 32'(err), 32'd1);
        check("e1_cnt", 32'(err_count), 32'd1);
        check("e1_we", 32'(mem_we), 32'd0);
        send(32'h00000063, 3'b101, 32'h3, 1'b0);
        check("e2_cnt", 32'(err_count), 32'd2);
        send(32'h00000093, 3'b011, 32'h0, 1'b0);
        check("e3_cnt", 32'(err_count), 32'd3);
        send(32'h00000093, 3'b000, 32'h5, 1'b0);
        check("e_idx_addr", mem_addr, 32'h600);
        for (int k = 0; k < 297; k++) send(32'h00000093, 3'b000, 32'h800, k == 296);
        wait_idle();
        check("sat_cnt", 32'(err_count), 32'd255);
        check("sat_err", 32'(err), 32'd1);
        check("sat_nwr", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) check("sat_data", wq[0].data, 32'h00500093);
        do_start(32'h0);
        check("clr_err", 32'(err), 32'd0);
        check("clr_cnt", 32'(err_count), 32'd0);
        send(32'h00000093, 3'b011, 32'h0, 1'b1);
        wait_idle();

        // Backpressure: held output stays stable, input stalls, nothing lost or duplicated
        wq.delete();
        do_start(32'h300);
        mem_ready = 1'b0;
        send(32'h00000093, 3'b000, 32'h1, 1'b0);
        in_valid = 1'b1;
        in_tmpl = 32'h00000093;
        in_src = 3'b000;
        in_imm = 32'h2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_we", 32'(mem_we), 32'd1);
            check("bp_addr", mem_addr, 32'h300);
            check("bp_data", mem_wdata, 32'h00100093);
            tick();
        end
        mem_ready = 1'b1;
        send(32'h00000093, 3'b000, 32'h2, 1'b0);
        send(32'h00000093, 3'b000, 32'h3, 1'b1);
        wait_idle();
        check("bp_nwr", 32'(wq.size()), 32'd3);
        if (wq.size() == 3) begin
            check("bp_d0", wq[0].data, 32'h00100093);
            check("bp_a1", wq[1].addr, 32'h304);
            check("bp_d1", wq[1].data, 32'h00200093);
            check("bp_a2", wq[2].addr, 32'h308);
            check("bp_d2", wq[2].data, 32'h00300093);
        end

        // Index wrap with ADDR_W=2 and a single done pulse
        wq.delete();
        d0 = done_cnt;
        do_start(32'h0);
        for (int k = 1; k <= 5; k++) send(32'h00000093, 3'b000, 32'(k), k == 5);
        wait_idle();
        check("wrap_nwr", 32'(wq.size()), 32'd5);
        if (wq.size() == 5) begin
            check("wrap_a2", wq[2].addr, 32'h8);
            check("wrap_a3", wq[3].addr, 32'hC);
            check("wrap_a4", wq[4].addr, 32'h0);
            check("wrap_d4", wq[4].data, 32'h00500093);
        end
        check("wrap_done_once", 32'(done_cnt - d0), 32'd1);
        check("wrap_busy", 32'(busy), 32'd0);

        // Mid-session start ignored, reset drops the in-flight word
        wq.delete();
        do_start(32'h400);
        mem_ready = 1'b0;
        send(32'h00000093, 3'b000, 32'h800, 1'b0);
        send(32'h00000093, 3'b000, 32'h7, 1'b0);
        do_start(32'h500);
        check("mid_start_busy", 32'(busy), 32'd1);
        check("mid_start_cnt", 32'(err_count), 32'd1);
        check("mid_start_addr", mem_addr, 32'h400);
        check("mid_start_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_mid_we", 32'(mem_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_cnt", 32'(err_count), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        mem_ready = 1'b1;
        repeat (2) tick();
        check("rst_mid_nwr", 32'(wq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
